// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and the init command table for the
// HD44780-class line refresher.
package lcd_pkg;

   localparam logic [7:0] CMD_FUNC_SET_8BIT_2L = 8'h38;
   localparam logic [7:0] CMD_DISP_ON          = 8'h0C;
   localparam logic [7:0] CMD_CLEAR            = 8'h01;
   localparam logic [7:0] CMD_ENTRY_INC        = 8'h06;
   localparam logic [7:0] CMD_SET_DDRAM        = 8'h80;
   localparam logic [7:0] CHAR_SPACE           = 8'h20;

   localparam logic [2:0] INIT_LAST_STEP  = 3'd5;
   localparam logic [2:0] INIT_CLEAR_STEP = 3'd4;

   typedef enum logic [2:0] {
      S_POWERUP,
      S_INIT,
      S_IDLE,
      S_SET_ADDR,
      S_WR_CHAR
   } lcd_state_t;

   typedef enum logic [1:0] {
      B_IDLE,
      B_SETUP,
      B_PULSE,
      B_WAIT
   } bus_phase_t;

   // Function set is sent three times, as the panel's reset-by-instruction flow requires.
   function automatic logic [7:0] init_cmd(input logic [2:0] step);
      logic [7:0] cmd;
      case (step)
         3'd0, 3'd1, 3'd2: cmd = CMD_FUNC_SET_8BIT_2L;
         3'd3:             cmd = CMD_DISP_ON;
         3'd4:             cmd = CMD_CLEAR;
         default:          cmd = CMD_ENTRY_INC;
      endcase
      return cmd;
   endfunction

endpackage

// File: rtl/lcd_bus_cycle.sv
// One panel write: setup cycle, lcd_e strobe, then a programmable settle wait.
// done pulses during the final wait cycle; data and rs hold between cycles.
module lcd_bus_cycle
   import lcd_pkg::*;
#(
   parameter int E_PULSE_CYCLES = 25
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        rs_in,
   input  logic [7:0]  data_in,
   input  logic [31:0] wait_cycles,
   output logic        lcd_rs,
   output logic [7:0]  lcd_data,
   output logic        lcd_e,
   output logic        done
);

   bus_phase_t  phase_reg;
   logic [31:0] cnt_reg;
   logic [31:0] wait_reg;

   assign done = (phase_reg == B_WAIT) && (cnt_reg == wait_reg - 32'd1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase_reg <= B_IDLE;
         cnt_reg   <= '0;
         wait_reg  <= '0;
         lcd_rs    <= 1'b0;
         lcd_data  <= 8'h00;
         lcd_e     <= 1'b0;
      end else begin
         case (phase_reg)
            B_IDLE: begin
               if (start) begin
                  lcd_rs    <= rs_in;
                  lcd_data  <= data_in;
                  wait_reg  <= wait_cycles;
                  phase_reg <= B_SETUP;
               end
            end
            B_SETUP: begin
               lcd_e     <= 1'b1;
               cnt_reg   <= '0;
               phase_reg <= B_PULSE;
            end
            B_PULSE: begin
               if (cnt_reg == 32'(E_PULSE_CYCLES - 1)) begin
                  lcd_e     <= 1'b0;
                  cnt_reg   <= '0;
                  phase_reg <= B_WAIT;
               end else begin
                  cnt_reg <= cnt_reg + 32'd1;
               end
            end
            B_WAIT: begin
               if (done) phase_reg <= B_IDLE;
               else      cnt_reg   <= cnt_reg + 32'd1;
            end
            default: phase_reg <= B_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/lcd_line_refresher.sv
// Character-panel controller: power-up init, byte-write character buffer and
// round-robin refresh of only the lines marked dirty.
module lcd_line_refresher
   import lcd_pkg::*;
#(
   parameter int              LINES             = 4,
   parameter int              CHARS             = 20,
   parameter logic [0:3][6:0] LINE_STARTS       = {7'h00, 7'h40, 7'h14, 7'h54},
   parameter int              E_PULSE_CYCLES    = 25,
   parameter int              CMD_WAIT_CYCLES   = 2500,
   parameter int              CLEAR_WAIT_CYCLES = 100000,
   parameter int              POWERUP_CYCLES    = 2500000,
   localparam int             LW = (LINES > 1) ? $clog2(LINES) : 1,
   localparam int             CW = (CHARS > 1) ? $clog2(CHARS) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [LW-1:0] wr_line,
   input  logic [CW-1:0] wr_col,
   input  logic [7:0]    wr_char,
   output logic [7:0]    lcd_data,
   output logic          lcd_rs,
   output logic          lcd_rw,
   output logic          lcd_e,
   output logic          init_done,
   output logic          busy
);

   lcd_state_t     state_reg, state_next;
   logic [31:0]    pcnt_reg;
   logic [2:0]     step_reg;
   logic [LW-1:0]  line_reg, last_reg, sel_line;
   logic [CW-1:0]  col_reg;
   logic           pending_reg;
   logic           init_done_reg;
   logic [LINES-1:0] dirty_reg;
   logic [7:0]     char_buf [LINES][CHARS];

   logic           wr_valid, any_dirty, sel_fire, sel_found;
   logic           bus_start, bus_rs, bus_done;
   logic [7:0]     bus_data;
   logic [31:0]    bus_wait;
   int             rr_idx;

   assign wr_valid  = wr_en && (32'(wr_line) < LINES) && (32'(wr_col) < CHARS);
   assign any_dirty = |dirty_reg;
   assign sel_fire  = (state_reg == S_IDLE) && any_dirty;

   // Round-robin search starting just after the line refreshed last.
   always_comb begin
      sel_line  = last_reg;
      sel_found = 1'b0;
      rr_idx    = 0;
      for (int i = 1; i <= LINES; i++) begin
         rr_idx = (int'(last_reg) + i) % LINES;
         if (!sel_found && dirty_reg[LW'(rr_idx)]) begin
            sel_found = 1'b1;
            sel_line  = LW'(rr_idx);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_reg <= S_POWERUP;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_POWERUP:  if (pcnt_reg == 32'(POWERUP_CYCLES - 1)) state_next = S_INIT;
         S_INIT:     if (bus_done && step_reg == INIT_LAST_STEP) state_next = S_IDLE;
         S_IDLE:     if (any_dirty) state_next = S_SET_ADDR;
         S_SET_ADDR: if (bus_done) state_next = S_WR_CHAR;
         S_WR_CHAR:  if (bus_done && col_reg == CW'(CHARS - 1)) state_next = S_IDLE;
         default:    state_next = S_POWERUP;
      endcase
   end

   // The character byte is read combinationally in the cycle the bus cycle is launched.
   always_comb begin
      bus_start = 1'b0;
      bus_rs    = 1'b0;
      bus_data  = 8'h00;
      bus_wait  = 32'(CMD_WAIT_CYCLES);
      case (state_reg)
         S_INIT: begin
            bus_start = !pending_reg;
            bus_data  = init_cmd(step_reg);
            if (step_reg == INIT_CLEAR_STEP) bus_wait = 32'(CLEAR_WAIT_CYCLES);
         end
         S_SET_ADDR: begin
            bus_start = !pending_reg;
            bus_data  = CMD_SET_DDRAM | {1'b0, LINE_STARTS[2'(line_reg)]};
         end
         S_WR_CHAR: begin
            bus_start = !pending_reg;
            bus_rs    = 1'b1;
            bus_data  = char_buf[line_reg][col_reg];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pcnt_reg      <= '0;
         step_reg      <= '0;
         line_reg      <= '0;
         last_reg      <= LW'(LINES - 1);
         col_reg       <= '0;
         pending_reg   <= 1'b0;
         init_done_reg <= 1'b0;
         dirty_reg     <= '1;
         for (int l = 0; l < LINES; l++)
            for (int c = 0; c < CHARS; c++)
               char_buf[l][c] <= CHAR_SPACE;
      end else begin
         if (bus_start)     pending_reg <= 1'b1;
         else if (bus_done) pending_reg <= 1'b0;

         case (state_reg)
            S_POWERUP: pcnt_reg <= pcnt_reg + 32'd1;
            S_INIT: begin
               if (bus_done) begin
                  if (step_reg == INIT_LAST_STEP) init_done_reg <= 1'b1;
                  else                            step_reg      <= step_reg + 3'd1;
               end
            end
            S_IDLE: begin
               if (any_dirty) begin
                  line_reg <= sel_line;
                  col_reg  <= '0;
               end
            end
            S_WR_CHAR: begin
               if (bus_done) begin
                  if (col_reg == CW'(CHARS - 1)) last_reg <= line_reg;
                  else                           col_reg  <= col_reg + CW'(1);
               end
            end
            default: ;
         endcase

         // A write landing on the line being selected must leave it dirty.
         if (sel_fire) dirty_reg[sel_line] <= 1'b0;
         if (wr_valid) begin
            dirty_reg[wr_line]         <= 1'b1;
            char_buf[wr_line][wr_col]  <= wr_char;
         end
      end
   end

   lcd_bus_cycle #(
      .E_PULSE_CYCLES (E_PULSE_CYCLES)
   ) u_bus (
      .clk         (clk),
      .reset       (reset),
      .start       (bus_start),
      .rs_in       (bus_rs),
      .data_in     (bus_data),
      .wait_cycles (bus_wait),
      .lcd_rs      (lcd_rs),
      .lcd_data    (lcd_data),
      .lcd_e       (lcd_e),
      .done        (bus_done)
   );

   assign lcd_rw    = 1'b0;
   assign init_done = init_done_reg;
   assign busy      = (state_reg != S_IDLE) || any_dirty;

endmodule

// File: tb/tb_lcd_line_refresher.sv
// Bench for lcd_line_refresher: panel transactions are captured on every lcd_e
// rise and compared against streams built from a character-buffer model.
module tb_lcd_line_refresher;

   localparam int LINES = 2, CHARS = 4, EP = 2, CMDW = 5, CLRW = 12, PWR = 20;
   localparam logic [0:3][6:0] STARTS = {7'h00, 7'h40, 7'h14, 7'h54};

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_en = 1'b0;
   logic [0:0] wr_line = '0;
   logic [1:0] wr_col = '0;
   logic [7:0] wr_char = '0;
   logic [7:0] lcd_data;
   logic       lcd_rs, lcd_rw, lcd_e, init_done, busy;

   logic       wr2_en = 1'b0;
   logic [1:0] wr2_line = '0;
   logic [2:0] wr2_col = '0;
   logic [7:0] wr2_char = '0;
   logic [7:0] d2_data;
   logic       d2_rs, d2_rw, d2_e, d2_init_done, d2_busy;

   always #5 clk = ~clk;

   lcd_line_refresher #(
      .LINES(LINES), .CHARS(CHARS), .LINE_STARTS(STARTS), .E_PULSE_CYCLES(EP),
      .CMD_WAIT_CYCLES(CMDW), .CLEAR_WAIT_CYCLES(CLRW), .POWERUP_CYCLES(PWR)
   ) u_dut (
      .clk(clk), .reset(rst_n), .wr_en(wr_en), .wr_line(wr_line), .wr_col(wr_col),
      .wr_char(wr_char), .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
      .lcd_e(lcd_e), .init_done(init_done), .busy(busy)
   );

   // Second instance with non-power-of-two sizes so out-of-range writes are expressible.
   lcd_line_refresher #(
      .LINES(3), .CHARS(5), .LINE_STARTS(STARTS), .E_PULSE_CYCLES(EP),
      .CMD_WAIT_CYCLES(CMDW), .CLEAR_WAIT_CYCLES(CLRW), .POWERUP_CYCLES(PWR)
   ) u_dut2 (
      .clk(clk), .reset(rst_n), .wr_en(wr2_en), .wr_line(wr2_line), .wr_col(wr2_col),
      .wr_char(wr2_char), .lcd_data(d2_data), .lcd_rs(d2_rs), .lcd_rw(d2_rw),
      .lcd_e(d2_e), .init_done(d2_init_done), .busy(d2_busy)
   );

   typedef struct { logic rs; logic [7:0] data; int gap; logic idone; } txn_t;
   typedef struct { logic rs; logic [7:0] data; } exp_t;
   typedef struct { int line; int col; logic [7:0] ch; int exp_txns; logic exp_busy; } vec_t;

   txn_t cap_q[$];
   exp_t exp_q[$];
   logic [7:0] model_buf [LINES][CHARS];

   int   n_vec = 0, n_bad = 0;
   int   cyc = 0, fall_cyc = 0, e_hi = 0, e2_rises = 0;
   logic e_prev = 1'b0, e2_prev = 1'b0;

   task automatic chk(input string name, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic chk_ge(input string name, input int act, input int lo);
      n_vec++;
      if (act < lo) begin
         n_bad++;
         $display("FAIL %s: got %0d, required at least %0d", name, act, lo);
      end
   endtask

   // Bus monitor: records each strobe and checks the strobe width.
   always @(negedge clk) begin
      txn_t t;
      cyc++;
      if (!rst_n) begin
         e_prev = 1'b0; e_hi = 0; fall_cyc = cyc; e2_prev = 1'b0;
      end else begin
         if (lcd_e && !e_prev) begin
            t.rs = lcd_rs; t.data = lcd_data; t.gap = cyc - fall_cyc; t.idone = init_done;
            cap_q.push_back(t);
         end
         if (lcd_e) e_hi++;
         if (!lcd_e && e_prev) begin
            chk("e_width", e_hi, EP);
            e_hi = 0;
            fall_cyc = cyc;
         end
         e_prev = lcd_e;
         if (d2_e && !e2_prev) e2_rises++;
         e2_prev = d2_e;
      end
   end

   task automatic push_exp(input logic rs, input logic [7:0] d);
      exp_t e;
      e.rs = rs; e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic expect_init();
      push_exp(1'b0, 8'h38); push_exp(1'b0, 8'h38); push_exp(1'b0, 8'h38);
      push_exp(1'b0, 8'h0C); push_exp(1'b0, 8'h01); push_exp(1'b0, 8'h06);
   endtask

   task automatic expect_line(input int l);
      logic [1:0] li;
      li = 2'(l);
      push_exp(1'b0, 8'h80 | {1'b0, STARTS[li]});
      for (int c = 0; c < CHARS; c++) push_exp(1'b1, model_buf[l][c]);
   endtask

   task automatic compare_stream(input string name);
      for (int i = 0; i < exp_q.size(); i++) begin
         n_vec++;
         if (i >= cap_q.size()) begin
            n_bad++;
            $display("FAIL %s[%0d]: got no transaction, required rs=%0d data=%02h",
                     name, i, exp_q[i].rs, exp_q[i].data);
         end else if (cap_q[i].rs !== exp_q[i].rs || cap_q[i].data !== exp_q[i].data) begin
            n_bad++;
            $display("FAIL %s[%0d]: got rs=%0d data=%02h, required rs=%0d data=%02h",
                     name, i, cap_q[i].rs, cap_q[i].data, exp_q[i].rs, exp_q[i].data);
         end
      end
      chk({name, ".count"}, cap_q.size(), exp_q.size());
      cap_q.delete();
      exp_q.delete();
   endtask

   task automatic wait_idle(input string name, input int budget);
      int k = 0;
      while (busy && k < budget) begin
         @(negedge clk); #1;
         k++;
      end
      chk({name, ".idle"}, int'(busy), 0);
   endtask

   task automatic do_write(input int l, input int c, input logic [7:0] ch);
      wr_line = 1'(l); wr_col = 2'(c); wr_char = ch; wr_en = 1'b1;
      @(negedge clk); #1;
      wr_en = 1'b0;
      model_buf[l][c] = ch;
   endtask

   task automatic do_write2(input int l1, input int c1, input logic [7:0] ch1,
                            input int l2, input int c2, input logic [7:0] ch2);
      wr_line = 1'(l1); wr_col = 2'(c1); wr_char = ch1; wr_en = 1'b1;
      @(negedge clk); #1;
      model_buf[l1][c1] = ch1;
      wr_line = 1'(l2); wr_col = 2'(c2); wr_char = ch2;
      @(negedge clk); #1;
      wr_en = 1'b0;
      model_buf[l2][c2] = ch2;
   endtask

   task automatic model_reset();
      for (int l = 0; l < LINES; l++)
         for (int c = 0; c < CHARS; c++) model_buf[l][c] = 8'h20;
   endtask

   // Startup stream: powerup gap, six init commands with their waits, then every line.
   task automatic check_startup(input string name);
      wait_idle(name, 1500);
      if (cap_q.size() >= 7) begin
         chk_ge({name, ".powerup_gap"}, cap_q[0].gap, PWR);
         for (int i = 1; i < 6; i++)
            chk_ge($sformatf("%s.wait%0d", name, i), cap_q[i].gap, ((i == 5) ? CLRW : CMDW) + 1);
         chk({name, ".init_done_at_06"}, int'(cap_q[5].idone), 0);
         chk({name, ".init_done_at_80"}, int'(cap_q[6].idone), 1);
      end else begin
         chk({name, ".short_stream"}, cap_q.size(), 16);
      end
      expect_init();
      for (int l = 0; l < LINES; l++) expect_line(l);
      compare_stream(name);
      chk({name, ".init_done"}, int'(init_done), 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[5];
      int   l1, c1, l2, c2, k, rises0;
      logic dropped;
      logic [7:0] snap [CHARS];

      tbl = '{'{1, 2, 8'h41, 5, 1'b1}, '{0, 0, 8'h48, 5, 1'b1}, '{0, 3, 8'h21, 5, 1'b1},
              '{1, 3, 8'h7E, 5, 1'b1}, '{1, 1, 8'h30, 5, 1'b1}};
      model_reset();

      // Reset values
      repeat (3) @(negedge clk);
      #1;
      chk("rst.lcd_e", int'(lcd_e), 0);
      chk("rst.lcd_rs", int'(lcd_rs), 0);
      chk("rst.lcd_rw", int'(lcd_rw), 0);
      chk("rst.lcd_data", int'(lcd_data), 0);
      chk("rst.init_done", int'(init_done), 0);
      chk("rst.busy", int'(busy), 1);
      rst_n = 1'b1;
      check_startup("startup");

      // Single writes from the table
      for (int v = 0; v < 5; v++) begin
         $display("vec %0d: line %0d col %0d char %02h", v, tbl[v].line, tbl[v].col, tbl[v].ch);
         do_write(tbl[v].line, tbl[v].col, tbl[v].ch);
         chk($sformatf("tbl%0d.busy", v), int'(busy), int'(tbl[v].exp_busy));
         wait_idle($sformatf("tbl%0d", v), 300);
         chk($sformatf("tbl%0d.ntxn", v), cap_q.size(), tbl[v].exp_txns);
         expect_line(tbl[v].line);
         compare_stream($sformatf("tbl%0d", v));
      end

      // Random single writes
      for (int r = 0; r < 6; r++) begin
         l1 = $urandom_range(0, LINES - 1);
         c1 = $urandom_range(0, CHARS - 1);
         $display("rnd %0d: line %0d col %0d", r, l1, c1);
         do_write(l1, c1, 8'($urandom_range(8'h21, 8'h7E)));
         wait_idle($sformatf("rnd%0d", r), 300);
         expect_line(l1);
         compare_stream($sformatf("rnd%0d", r));
      end

      // Back-to-back writes: line 0 then line 1, then the same line twice
      $display("pair: line 0 then line 1");
      do_write2(0, 1, 8'h61, 1, 2, 8'h62);
      wait_idle("pair01", 400);
      expect_line(0); expect_line(1);
      compare_stream("pair01");

      $display("pair: line 0 twice");
      do_write2(0, 1, 8'h51, 0, 2, 8'h52);
      wait_idle("pair00", 400);
      expect_line(0); expect_line(0);
      compare_stream("pair00");

      for (int r = 0; r < 4; r++) begin
         l1 = $urandom_range(0, LINES - 1); c1 = $urandom_range(0, CHARS - 1);
         l2 = $urandom_range(0, LINES - 1); c2 = $urandom_range(0, CHARS - 1);
         $display("rpair %0d: line %0d col %0d, line %0d col %0d", r, l1, c1, l2, c2);
         do_write2(l1, c1, 8'($urandom_range(8'h21, 8'h7E)), l2, c2, 8'($urandom_range(8'h21, 8'h7E)));
         wait_idle($sformatf("rpair%0d", r), 400);
         expect_line(l1); expect_line(l2);
         compare_stream($sformatf("rpair%0d", r));
      end

      // Writes to line 0 while its column 1 is on the bus
      $display("midpass: line 0 col 0 and col 3 during col 1 strobe");
      do_write(0, 2, 8'h4D);
      k = 0;
      while (cap_q.size() < 3 && k < 200) begin
         @(negedge clk); #1;
         k++;
      end
      chk("midpass.reach_col1", cap_q.size(), 3);
      for (int c = 0; c < CHARS; c++) snap[c] = model_buf[0][c];
      do_write2(0, 0, 8'h5A, 0, 3, 8'h59);
      push_exp(1'b0, 8'h80);
      push_exp(1'b1, snap[0]); push_exp(1'b1, snap[1]); push_exp(1'b1, snap[2]);
      push_exp(1'b1, 8'h59);
      expect_line(0);
      dropped = 1'b0;
      k = 0;
      while (cap_q.size() < 10 && k < 400) begin
         if (!busy) dropped = 1'b1;
         @(negedge clk); #1;
         k++;
      end
      chk("midpass.busy_dropped", int'(dropped), 0);
      wait_idle("midpass", 200);
      compare_stream("midpass");

      // Out-of-range writes on the 3-line, 5-column instance
      k = 0;
      while (d2_busy && k < 1000) begin
         @(negedge clk); #1;
         k++;
      end
      chk("oor.start_idle", int'(d2_busy), 0);
      rises0 = e2_rises;
      for (int v = 0; v < 3; v++) begin
         wr2_line = (v == 0) ? 2'd3 : 2'(v - 1);
         wr2_col  = (v == 0) ? 3'd0 : ((v == 1) ? 3'd5 : 3'd7);
         wr2_char = 8'h41;
         $display("oor %0d: line %0d col %0d", v, wr2_line, wr2_col);
         wr2_en = 1'b1;
         @(negedge clk); #1;
         wr2_en = 1'b0;
         repeat (20) @(negedge clk);
         #1;
         chk($sformatf("oor%0d.busy", v), int'(d2_busy), 0);
      end
      chk("oor.no_strobe", e2_rises - rises0, 0);
      wr2_line = 2'd2; wr2_col = 3'd4; wr2_en = 1'b1;
      @(negedge clk); #1;
      wr2_en = 1'b0;
      chk("oor.valid_busy", int'(d2_busy), 1);

      // Reset during a data strobe aborts and restarts the whole sequence
      $display("abort: reset during data strobe");
      do_write(1, 0, 8'h4B);
      k = 0;
      while (!(lcd_e && lcd_rs) && k < 200) begin
         @(negedge clk); #1;
         k++;
      end
      chk("abort.reach_data", int'(lcd_e && lcd_rs), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort.lcd_e", int'(lcd_e), 0);
      chk("abort.init_done", int'(init_done), 0);
      chk("abort.busy", int'(busy), 1);
      cap_q.delete();
      model_reset();
      repeat (3) @(negedge clk);
      #1;
      rst_n = 1'b1;
      check_startup("restart");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
